// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the uart_tx / uart_rx / arbiter slice: byte width, the default
// baud prescaler and the arbiter state encoding.
package uart_tx_arb_pkg;

  localparam int unsigned ByteW = 8;

  // 100 MHz / 9600 Bd
  localparam int unsigned PrescaleDivDefault = 10417;

  localparam int unsigned StallW = 16;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: returns the first requester strictly after last_i,
// wrapping modulo NUM_SRC.
module uart_tx_arb_rr_pick #(
  parameter int unsigned  NUM_SRC = 2,
  localparam int unsigned IdxW    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IdxW-1:0]    last_i,
  output logic               any_o,
  output logic [IdxW-1:0]    idx_o
);

  logic [2*NUM_SRC-1:0] req_dbl;
  logic [NUM_SRC-1:0]   req_rot;
  int unsigned          start;
  int unsigned          pos;
  int unsigned          sum;

  always_comb begin
    start = 32'(last_i) + 32'd1;
    if (start >= NUM_SRC) begin
      start = 0;
    end

    // Rotate so the slot after last_i sits at bit 0, then take the lowest set bit.
    req_dbl = {req_i, req_i};
    req_rot = NUM_SRC'(req_dbl >> start);

    pos = 0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pos = 32'(i);
      end
    end

    sum = start + pos;
    if (sum >= NUM_SRC) begin
      sum = sum - NUM_SRC;
    end
    if (sum > NUM_SRC - 1) begin
      sum = NUM_SRC - 1;
    end

    any_o = |req_i;
    idx_o = IdxW'(sum);
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter: NUM_SRC byte sources share one uart_tx stream through a
// one-entry output register; a grant stalled for IDLE_TIMEOUT cycles is revoked.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned  NUM_SRC      = 2,
  parameter int unsigned  IDLE_TIMEOUT = 4096,
  localparam int unsigned IdxW         = $clog2(NUM_SRC)
) (
  input  logic                     aclk,
  input  logic                     rst,
  input  logic [NUM_SRC*ByteW-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]       s_tvalid,
  input  logic [NUM_SRC-1:0]       s_tlast,
  output logic [NUM_SRC-1:0]       s_tready,
  output logic [ByteW-1:0]         m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     grant_valid,
  output logic [IdxW-1:0]          grant_idx,
  output logic                     timeout_evt
);

  arb_state_e       state_q, state_d;
  logic [IdxW-1:0]  grant_q, grant_d;
  logic [IdxW-1:0]  last_q, last_d;
  logic             tev_q, tev_d;

  logic             out_valid_q, out_valid_d;
  logic [ByteW-1:0] out_data_q, out_data_d;

  logic             pick_any;
  logic [IdxW-1:0]  pick_idx;

  logic             src_valid;
  logic             src_last;
  logic [ByteW-1:0] src_data;
  logic             out_free;
  logic             accept;
  logic             stall_hit;

  uart_tx_arb_rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req_i  (s_tvalid),
    .last_i (last_q),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );

  // Granted source lane.
  always_comb begin
    src_valid = 1'b0;
    src_last  = 1'b0;
    src_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == IdxW'(i)) begin
        src_valid = s_tvalid[i];
        src_last  = s_tlast[i];
        src_data  = s_tdata[i*ByteW +: ByteW];
      end
    end
  end

  // Register can take a byte when empty or when it drains this same cycle.
  assign out_free = !out_valid_q || m_tready;
  assign accept   = (state_q == StGrant) && src_valid && out_free;

  always_comb begin
    s_tready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if ((state_q == StGrant) && (grant_q == IdxW'(i))) begin
        s_tready[i] = out_free;
      end
    end
  end

  // Stall timer exists only when revocation is enabled.
  localparam int unsigned StallLimit = (IDLE_TIMEOUT == 0)     ? 0 :
                                       (IDLE_TIMEOUT > 65536) ? 65535 : IDLE_TIMEOUT - 1;

  if (IDLE_TIMEOUT > 0) begin : g_timeout
    logic [StallW-1:0] stall_q, stall_d;

    always_comb begin
      stall_d = stall_q;
      if ((state_q != StGrant) || src_valid) begin
        stall_d = '0;
      end else if (stall_q != {StallW{1'b1}}) begin
        stall_d = stall_q + 1'b1;
      end
    end

    always_ff @(posedge aclk) begin
      if (rst) begin
        stall_q <= '0;
      end else begin
        stall_q <= stall_d;
      end
    end

    assign stall_hit = (state_q == StGrant) && !src_valid &&
                       (stall_q == StallW'(StallLimit));
  end else begin : g_no_timeout
    assign stall_hit = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    tev_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d = StGrant;
          grant_d = pick_idx;
        end
      end
      StGrant: begin
        if ((accept && src_last) || stall_hit) begin
          state_d = StIdle;
          last_d  = grant_q;
          grant_d = '0;
          tev_d   = stall_hit;
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdxW'(NUM_SRC - 1);
      tev_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      tev_q   <= tev_d;
    end
  end

  always_comb begin
    out_valid_d = accept || (out_valid_q && !m_tready);
    out_data_d  = accept ? src_data : out_data_q;
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign m_tvalid    = out_valid_q;
  assign m_tdata     = out_data_q;
  assign grant_valid = (state_q == StGrant);
  assign grant_idx   = grant_q;
  assign timeout_evt = tev_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: packet-level behavioural model compared every cycle, plus directed
// scenarios with literal expectations on the observed byte stream.
module tb_uart_tx_arb;

  localparam int unsigned N  = 2;
  localparam int unsigned TO = 16;

  logic           aclk = 1'b0;
  logic           rst;
  logic [N*8-1:0] s_tdata;
  logic [N-1:0]   s_tvalid;
  logic [N-1:0]   s_tlast;
  logic [N-1:0]   s_tready;
  logic [7:0]     m_tdata;
  logic           m_tvalid;
  logic           m_tready;
  logic           grant_valid;
  logic [0:0]     grant_idx;
  logic           timeout_evt;

  always #5 aclk = ~aclk;

  uart_tx_arb #(
    .NUM_SRC      (N),
    .IDLE_TIMEOUT (TO)
  ) dut (
    .aclk        (aclk),
    .rst         (rst),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .timeout_evt (timeout_evt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Per-source packet queues: {tlast, byte}
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction
  function automatic logic [8:0] qfront(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction
  task automatic qpush(input int i, input logic [8:0] v);
    if (i == 0) q0.push_back(v);
    else q1.push_back(v);
  endtask
  task automatic qpop(input int i);
    if (i == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  // Behavioural model: who owns the link, how long the owner has been silent, and
  // what sits in the single output slot.
  bit         md_ok = 0;
  int         owner;        // -1 when nobody holds the grant
  int         last_owner;
  int         quiet;
  bit         slot_full;
  logic [7:0] slot_byte;
  bit         tev_exp;
  bit         took[N];
  bit         drained;
  int         cyc = 0;

  always @(posedge aclk) begin
    int  cand;
    bit  acc;
    cyc++;
    for (int i = 0; i < N; i++) took[i] = 0;
    drained = 0;
    if (rst) begin
      md_ok = 1; owner = -1; last_owner = N - 1; quiet = 0;
      slot_full = 0; slot_byte = 8'h00; tev_exp = 0;
    end else if (md_ok) begin
      acc     = (owner >= 0) && s_tvalid[owner] && (!slot_full || m_tready);
      drained = slot_full && m_tready;
      tev_exp = 0;
      if (acc) begin
        took[owner] = 1;
        slot_full   = 1;
        slot_byte   = 8'(s_tdata >> (8 * owner));
      end else if (drained) begin
        slot_full = 0;
      end
      if (owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          cand = (last_owner + k) % N;
          if (owner < 0 && s_tvalid[cand]) begin
            owner = cand;
            quiet = 0;
          end
        end
      end else if (acc && s_tlast[owner]) begin
        last_owner = owner;
        owner      = -1;
      end else if (!s_tvalid[owner] && quiet == TO - 1) begin
        last_owner = owner;
        owner      = -1;
        tev_exp    = 1;
      end else begin
        quiet = s_tvalid[owner] ? 0 : ((quiet < 65535) ? quiet + 1 : 65535);
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge aclk) begin
    logic [N-1:0] exp_rdy;
    logic [13:0]  exp_vec;
    logic [13:0]  dut_vec;
    if (md_ok) begin
      exp_rdy = '0;
      if (owner >= 0 && (!slot_full || m_tready)) exp_rdy[owner] = 1'b1;
      exp_vec = {exp_rdy, slot_full, slot_full ? slot_byte : 8'h00,
                 owner >= 0, owner == 1, tev_exp};
      dut_vec = {s_tready, m_tvalid, m_tvalid ? m_tdata : 8'h00,
                 grant_valid, grant_idx, timeout_evt};
      chk("cycle", 32'(dut_vec), 32'(exp_vec));
    end
  end

  // Observed DUT handshakes (values at negedge are the ones the next posedge samples).
  logic [7:0] log_data[$];
  int         log_cyc[$];
  int         acc0_cyc[$];
  int         tev_count = 0;

  always @(negedge aclk) begin
    if (!rst && m_tvalid === 1'b1 && m_tready) begin
      log_data.push_back(m_tdata);
      log_cyc.push_back(cyc);
    end
    if (!rst && s_tvalid[0] && s_tready[0] === 1'b1) acc0_cyc.push_back(cyc);
    if (timeout_evt === 1'b1) tev_count++;
  end

  function automatic logic [31:0] logv(input int idx);
    return (idx < log_data.size()) ? 32'(log_data[idx]) : 32'hdead_0000;
  endfunction
  function automatic int logc(input int idx);
    return (idx < log_cyc.size()) ? log_cyc[idx] : -1;
  endfunction

  // Stimulus driver: sources hold valid until accepted; uart_tx model stalls after each byte.
  int rmode   = 2;   // 0 random uart_tx, 1 always ready, 2 never ready
  int gap_pct = 0;
  int busy    = 0;

  always @(posedge aclk) begin
    logic [8:0] f;
    #1;
    if (drained) busy = $urandom_range(0, 3);
    else if (busy > 0) busy--;
    m_tready = (rmode == 1) ? 1'b1 : ((rmode == 2) ? 1'b0 : (busy == 0));
    for (int i = 0; i < N; i++) begin
      if (took[i]) qpop(i);
      if (s_tvalid[i] && !took[i] && !rst) begin
        // holding an offered byte
      end else if (qsize(i) > 0 && $urandom_range(0, 99) >= gap_pct) begin
        f = qfront(i);
        s_tvalid[i] = 1'b1;
        s_tlast[i]  = f[8];
        s_tdata[i*8 +: 8] = f[7:0];
      end else begin
        s_tvalid[i] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #3;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || slot_full || owner >= 0 || s_tvalid != '0)
           && n < 3000) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, 32'(n < 3000), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [7:0] fair_exp[4];
  int base, abase, tev0, n, pushed, len, src, hits, t_ev;

  initial begin
    rst = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b0;
    fair_exp[0] = 8'hA0; fair_exp[1] = 8'hA1; fair_exp[2] = 8'hB0; fair_exp[3] = 8'hB1;

    // Reset with every source requesting.
    qpush(0, {1'b1, 8'h01});
    qpush(1, {1'b1, 8'h02});
    repeat (3) tick();
    @(negedge aclk);
    chk("reset_outputs", 32'({s_tready, m_tvalid, m_tdata, grant_valid, grant_idx, timeout_evt}),
        32'd0);
    chk("reset_sources_requesting", 32'(s_tvalid), 32'd3);
    rst = 1'b0;
    @(negedge aclk);
    chk("first_grant_src0", 32'({grant_valid, grant_idx}), 32'b10);
    rmode = 0;
    wait_idle("reset");
    chk("reset_order0", logv(0), 32'h01);
    chk("reset_order1", logv(1), 32'h02);

    // Fairness with both sources streaming 2-byte packets.
    base = log_data.size();
    for (int k = 0; k < 4; k++) begin
      qpush(0, {1'b0, 8'hA0}); qpush(0, {1'b1, 8'hA1});
      qpush(1, {1'b0, 8'hB0}); qpush(1, {1'b1, 8'hB1});
    end
    wait_idle("fair");
    chk("fair_count", 32'(log_data.size() - base), 32'd16);
    for (int k = 0; k < 16; k++) chk("fair_order", logv(base + k), 32'(fair_exp[k % 4]));

    // Throughput with uart_tx always ready.
    rmode = 1;
    tick();
    base  = log_data.size();
    abase = acc0_cyc.size();
    for (int k = 0; k < 8; k++) qpush(0, {(k == 7), 8'(8'h10 + k)});
    wait_idle("thru");
    for (int k = 0; k < 8; k++) begin
      chk("thru_byte", logv(base + k), 32'(8'h10 + k));
      chk("thru_cycle", 32'(logc(base + k)), 32'((abase < acc0_cyc.size() ?
                                                 acc0_cyc[abase] : -100) + 1 + k));
    end

    // Backpressure: register full, uart_tx not ready for 20 cycles.
    rmode = 2;
    tick();
    base = log_data.size();
    qpush(1, {1'b1, 8'h55});
    qpush(1, {1'b1, 8'h56});
    repeat (20) tick();
    @(negedge aclk);
    chk("bp_hold", 32'({m_tvalid, m_tdata}), 32'h155);
    chk("bp_ready_low", 32'(s_tready[1]), 32'd0);
    chk("bp_regrant_src1", 32'({grant_valid, grant_idx}), 32'b11);
    chk("bp_no_handshake", 32'(log_data.size() - base), 32'd0);
    rmode = 0;
    wait_idle("bp");
    chk("bp_byte0", logv(base), 32'h55);
    chk("bp_byte1", logv(base + 1), 32'h56);

    // Timeout: src0 leaves a packet open, src1 waits.
    rmode = 1;
    tick();
    tev0  = tev_count;
    abase = acc0_cyc.size();
    qpush(0, {1'b0, 8'hAA});
    qpush(1, {1'b1, 8'h77});
    n = 0;
    @(negedge aclk);
    while (timeout_evt !== 1'b1 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    chk("to_seen", 32'(timeout_evt), 32'd1);
    t_ev = cyc;
    chk("to_delay", 32'(t_ev - ((abase < acc0_cyc.size()) ? acc0_cyc[abase] : 0)), 32'd17);
    @(negedge aclk);
    chk("to_pulse_width", 32'(timeout_evt), 32'd0);
    chk("to_next_grant", 32'({grant_valid, grant_idx}), 32'b11);
    wait_idle("to");
    chk("to_pulse_count", 32'(tev_count - tev0), 32'd1);

    // Reset while the output register holds an undelivered byte.
    rmode = 2;
    tick();
    base = log_data.size();
    qpush(0, {1'b1, 8'h3C});
    n = 0;
    @(negedge aclk);
    while (m_tvalid !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    chk("rst_loaded", 32'({m_tvalid, m_tdata}), 32'h13C);
    rst = 1'b1;
    @(negedge aclk);
    chk("rst_drop", 32'(m_tvalid), 32'd0);
    rst   = 1'b0;
    rmode = 0;
    repeat (10) tick();
    hits = 0;
    for (int k = base; k < log_data.size(); k++) if (log_data[k] == 8'h3C) hits++;
    chk("rst_discarded", 32'(hits), 32'd0);
    wait_idle("rst");

    // Random traffic with gaps, random uart_tx stalls and occasional open packets.
    gap_pct = 25;
    base    = log_data.size();
    pushed  = 0;
    for (int r = 0; r < 8; r++) begin
      for (int p = 0; p < 8; p++) begin
        src = $urandom_range(0, N - 1);
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          qpush(src, {(b == len - 1) && ($urandom_range(0, 9) != 0), 8'($urandom)});
          pushed++;
        end
      end
      wait_idle("rand");
    end
    chk("rand_bytes", 32'(log_data.size() - base), 32'(pushed));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
